// File: rtl/mine_placer.sv
// Minesweeper board generator: places NUM_MINES distinct mines from a random byte stream,
// never on the first-click cell, then scans the board once to fill in neighbour counts.
module mine_placer #(
  parameter int NUM_MINES = 40  // legal range 1..254
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] safe_idx,
  input  logic [7:0] rand_in,
  input  logic [7:0] rd_idx,
  output logic       rd_mine,
  output logic [3:0] rd_count,
  output logic       busy,
  output logic       done,
  output logic [7:0] placed,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_COUNT, S_DONE} state_t;

  localparam logic [7:0] NM = 8'(NUM_MINES);

  state_t      state_q, state_d;
  logic [7:0]  placed_q, placed_d;
  logic [7:0]  salt_q, salt_d;
  logic [7:0]  safe_q, safe_d;
  logic [7:0]  idx_q, idx_d;
  logic [255:0] mine_q;
  logic [3:0]  cnt_q [256];

  logic        clr_board;
  logic        set_mine;
  logic        wr_cnt;
  logic [7:0]  cand;
  logic [3:0]  nbr_cnt;
  int          rr;
  int          cc;
  logic [7:0]  nidx;

  // Salt lets the candidate reach 0x00, which an LFSR byte never produces on its own.
  assign cand = rand_in ^ salt_q;

  // Neighbour count of the cell under the scan index; rows and columns clip, never wrap.
  always_comb begin
    nbr_cnt = '0;
    rr      = 0;
    cc      = 0;
    nidx    = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr   = int'(idx_q[7:4]) + dr;
        cc   = int'(idx_q[3:0]) + dc;
        nidx = 8'(rr * 16 + cc);
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr <= 15 && cc >= 0 && cc <= 15)
          nbr_cnt = nbr_cnt + 4'(mine_q[nidx]);
      end
    end
  end

  // start is a one-cycle request with no ready: it is taken only in IDLE or DONE and
  // silently dropped while busy.
  always_comb begin
    state_d   = state_q;
    placed_d  = placed_q;
    salt_d    = salt_q;
    safe_d    = safe_q;
    idx_d     = idx_q;
    clr_board = 1'b0;
    set_mine  = 1'b0;
    wr_cnt    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_PLACE;
          clr_board = 1'b1;
          placed_d  = '0;
          salt_d    = '0;
          safe_d    = safe_idx;
          idx_d     = '0;
        end
      end
      S_PLACE: begin
        salt_d = salt_q + 8'd1;
        if (cand != safe_q && !mine_q[cand]) begin
          set_mine = 1'b1;
          placed_d = placed_q + 8'd1;
          if (placed_q + 8'd1 == NM) begin
            state_d = S_COUNT;
            idx_d   = '0;
          end
        end
      end
      S_COUNT: begin
        wr_cnt = 1'b1;
        idx_d  = idx_q + 8'd1;
        if (idx_q == 8'hFF) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      placed_q <= '0;
      salt_q   <= '0;
      safe_q   <= '0;
      idx_q    <= '0;
      mine_q   <= '0;
      for (int i = 0; i < 256; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      placed_q <= placed_d;
      salt_q   <= salt_d;
      safe_q   <= safe_d;
      idx_q    <= idx_d;
      if (clr_board) begin
        mine_q <= '0;
        for (int i = 0; i < 256; i++) cnt_q[i] <= '0;
      end else begin
        if (set_mine) mine_q[cand] <= 1'b1;
        if (wr_cnt)   cnt_q[idx_q] <= nbr_cnt;
      end
    end
  end

  assign rd_mine   = mine_q[rd_idx];
  assign rd_count  = cnt_q[rd_idx];
  assign busy      = (state_q == S_PLACE) || (state_q == S_COUNT);
  assign done      = (state_q == S_DONE);
  assign placed    = placed_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: three instances (40, 2 and 1 mines) checked against a board-level
// model every cycle, plus directed timing and cell-count expectations.
module tb_mine_placer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_s [NI];
  logic [7:0] safe_s  [NI];
  logic [7:0] rand_s  [NI];
  logic [7:0] rdi_s   [NI];
  logic       rdm_s   [NI];
  logic [3:0] rdc_s   [NI];
  logic       busy_s  [NI];
  logic       done_s  [NI];
  logic [7:0] placed_s[NI];
  logic [1:0] dbg_s   [NI];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mine_placer #(.NUM_MINES(40)) u_m40 (
    .clk(clk), .reset(reset), .start(start_s[0]), .safe_idx(safe_s[0]), .rand_in(rand_s[0]),
    .rd_idx(rdi_s[0]), .rd_mine(rdm_s[0]), .rd_count(rdc_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .placed(placed_s[0]), .dbg_state(dbg_s[0]));

  mine_placer #(.NUM_MINES(2)) u_m2 (
    .clk(clk), .reset(reset), .start(start_s[1]), .safe_idx(safe_s[1]), .rand_in(rand_s[1]),
    .rd_idx(rdi_s[1]), .rd_mine(rdm_s[1]), .rd_count(rdc_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .placed(placed_s[1]), .dbg_state(dbg_s[1]));

  mine_placer #(.NUM_MINES(1)) u_m1 (
    .clk(clk), .reset(reset), .start(start_s[2]), .safe_idx(safe_s[2]), .rand_in(rand_s[2]),
    .rd_idx(rdi_s[2]), .rd_mine(rdm_s[2]), .rd_count(rdc_s[2]), .busy(busy_s[2]),
    .done(done_s[2]), .placed(placed_s[2]), .dbg_state(dbg_s[2]));

  // scoreboard model: board contents and progress counters per instance
  bit m_map  [NI][256];
  bit m_busy [NI];
  bit m_done [NI];
  int m_placed[NI];
  int m_salt [NI];
  int m_safe [NI];
  int m_left [NI];

  function automatic int nm(input int i);
    return (i == 0) ? 40 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int nbr(input int i, input int idx);
    int r = idx / 16;
    int c = idx % 16;
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
          s += int'(m_map[i][(r + dr) * 16 + (c + dc)]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        if (!m_busy[i]) begin
          if (start_s[i]) begin
            for (int j = 0; j < 256; j++) m_map[i][j] = 1'b0;
            m_placed[i] = 0;
            m_salt[i]   = 0;
            m_safe[i]   = int'(safe_s[i]);
            m_busy[i]   = 1'b1;
            m_done[i]   = 1'b0;
            m_left[i]   = 0;
          end
        end else if (m_placed[i] < nm(i)) begin
          int cand;
          cand = int'(rand_s[i] ^ 8'(m_salt[i]));
          m_salt[i] = (m_salt[i] + 1) % 256;
          if (cand != m_safe[i] && !m_map[i][cand]) begin
            m_map[i][cand] = 1'b1;
            m_placed[i]++;
            if (m_placed[i] == nm(i)) m_left[i] = 256;
          end
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 256; j++) m_map[i][j] = 1'b0;
      m_busy[i]   = 1'b0;
      m_done[i]   = 1'b0;
      m_placed[i] = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("busy[%0d]", i), int'(busy_s[i]), int'(m_busy[i]));
          chk($sformatf("done[%0d]", i), int'(done_s[i]), int'(m_done[i]));
          chk($sformatf("placed[%0d]", i), int'(placed_s[i]), m_placed[i]);
          if (m_done[i]) begin
            chk($sformatf("rd_mine[%0d]@%0h", i, rdi_s[i]), int'(rdm_s[i]),
                int'(m_map[i][rdi_s[i]]));
            chk($sformatf("rd_count[%0d]@%0h", i, rdi_s[i]), int'(rdc_s[i]),
                nbr(i, int'(rdi_s[i])));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input int i, input logic [7:0] safe, output int k);
    @(negedge clk);
    start_s[i] = 1'b1;
    safe_s[i]  = safe;
    @(negedge clk);
    start_s[i] = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int i, input int budget, output int e);
    e = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done_s[i]) begin
        e = cyc;
        break;
      end
    end
  endtask

  task automatic rd_cell(input int i, input int idx, input int em, input int ec, input string nm_s);
    @(negedge clk);
    rdi_s[i] = 8'(idx);
    #1;
    chk({nm_s, "_mine"}, int'(rdm_s[i]), em);
    chk({nm_s, "_count"}, int'(rdc_s[i]), ec);
  endtask

  initial begin
    int k;
    int e;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      safe_s[i]  = 8'h00;
      rand_s[i]  = 8'h00;
      rdi_s[i]   = 8'h00;
    end

    // reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rdi_s[i] = 8'h5A;
      #1;
      chk("rst_busy", int'(busy_s[i]), 0);
      chk("rst_done", int'(done_s[i]), 0);
      chk("rst_placed", int'(placed_s[i]), 0);
      chk("rst_rd_mine", int'(rdm_s[i]), 0);
      chk("rst_rd_count", int'(rdc_s[i]), 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // sweep placement with ignored starts in PLACE and COUNT
    rand_s[0] = 8'h00;
    pulse_start(0, 8'h05, k);
    #1;
    chk("sweep_busy_after_accept", int'(busy_s[0]), 1);
    e = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      start_s[0] = (cyc == k + 10 || cyc == k + 100);
      if (done_s[0]) begin
        e = cyc;
        start_s[0] = 1'b0;
        break;
      end
    end
    chk("sweep_done_edge", e - k, 297);
    chk("sweep_placed", int'(placed_s[0]), 40);
    rd_cell(0, 8'h05, 0, 5, "c05");
    rd_cell(0, 8'h35, 0, 3, "c35");
    rd_cell(0, 8'h39, 0, 1, "c39");
    rd_cell(0, 8'h0F, 1, 3, "c0F");
    rd_cell(0, 8'h10, 1, 5, "c10");
    rd_cell(0, 8'hFF, 0, 0, "cFF");
    for (int idx = 0; idx < 256; idx++) begin
      @(negedge clk);
      rdi_s[0] = 8'(idx);
      #1;
      chk("sweep_map", int'(rdm_s[0]), (idx <= 8'h28 && idx != 5) ? 1 : 0);
    end

    // regeneration from DONE
    rand_s[0] = 8'h80;
    pulse_start(0, 8'h80, k);
    #1;
    chk("regen_done_drop", int'(done_s[0]), 0);
    chk("regen_busy", int'(busy_s[0]), 1);
    wait_done(0, 400, e);
    chk("regen_done_edge", e - k, 297);
    chk("regen_placed", int'(placed_s[0]), 40);
    for (int idx = 0; idx < 256; idx++) begin
      @(negedge clk);
      rdi_s[0] = 8'(idx);
      #1;
      chk("regen_map", int'(rdm_s[0]), (idx >= 8'h81 && idx <= 8'hA8) ? 1 : 0);
    end

    // duplicate rejection: candidate pinned at 0x33
    pulse_start(1, 8'h00, k);
    for (int j = 1; j <= 500; j++) begin
      rand_s[1] = 8'((j - 1) % 256) ^ 8'h33;
      @(negedge clk);
    end
    #1;
    chk("dup_placed", int'(placed_s[1]), 1);
    chk("dup_busy", int'(busy_s[1]), 1);
    chk("dup_done", int'(done_s[1]), 0);
    rdi_s[1] = 8'h33;
    #1;
    chk("dup_mine33", int'(rdm_s[1]), 1);
    rdi_s[1] = 8'h34;
    #1;
    chk("dup_mine34", int'(rdm_s[1]), 0);

    // safe cell at 0x00
    rand_s[2] = 8'h00;
    pulse_start(2, 8'h00, k);
    wait_done(2, 400, e);
    chk("safe_done_edge", e - k, 258);
    rd_cell(2, 8'h00, 0, 1, "s00");
    rd_cell(2, 8'h01, 1, 0, "s01");
    rd_cell(2, 8'h11, 0, 1, "s11");

    // rerun and reset mid-COUNT
    rand_s[0] = 8'h00;
    pulse_start(0, 8'h05, k);
    e = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (cyc == k + 150) begin
        e = cyc;
        break;
      end
    end
    chk("midcount_reached", e - k, 150);
    chk("midcount_busy", int'(busy_s[0]), 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", int'(busy_s[0]), 0);
    chk("arst_done", int'(done_s[0]), 0);
    chk("arst_placed", int'(placed_s[0]), 0);
    for (int idx = 0; idx < 256; idx++) begin
      rdi_s[0] = 8'(idx);
      #1;
      chk("arst_rd_mine", int'(rdm_s[0]), 0);
      chk("arst_rd_count", int'(rdc_s[0]), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_idle_busy", int'(busy_s[0]), 0);
    chk("post_rst_idle_done", int'(done_s[0]), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
